// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. Operands are registered toward the ALU, and each
// result is returned through a one-entry response buffer for its requester.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    // ALU side
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    // response 0
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    // response 1
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t state;
    logic   owner;       // requester that owns the EXEC operation
    logic   last_grant;  // requester granted most recently
    logic   elig0, elig1;
    logic   cand0, cand1;
    logic   grant0, grant1;

    // Eligibility and round-robin grant; a buffer being drained this cycle frees its requester
    always_comb begin
        elig0  = !((state == EXEC) && (owner == 1'b0)) && (!rsp0_valid || rsp0_ready);
        elig1  = !((state == EXEC) && (owner == 1'b1)) && (!rsp1_valid || rsp1_ready);
        cand0  = req0_valid && elig0;
        cand1  = req1_valid && elig1;
        grant0 = cand0 && (!cand1 || (last_grant == 1'b1));
        grant1 = cand1 && (!cand0 || (last_grant == 1'b0));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == EXEC) || rsp0_valid || rsp1_valid;

    // Sequencer: drain responses, capture the EXEC result, load the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            // The owner's buffer is always empty here: it was free or draining when granted.
            if (state == EXEC) begin
                if (owner == 1'b0) begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= alu_result;
                    rsp0_zero   <= alu_zero;
                end else begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= alu_result;
                    rsp1_zero   <= alu_zero;
                end
            end

            if (grant0 || grant1) begin
                alu_a      <= grant1 ? req1_a  : req0_a;
                alu_b      <= grant1 ? req1_b  : req0_b;
                alu_op     <= grant1 ? req1_op : req0_op;
                owner      <= grant1;
                last_grant <= grant1;
                state      <= EXEC;
            end else begin
                state      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU beside the DUT.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_result, rsp1_result;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned g_id[$];
    int unsigned g_cyc[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .busy(busy)
    );

    // Behavioural ALU standing in for the neighbouring block
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[4:0];
            OP_SRL:  alu_result = alu_a >> alu_b[4:0];
            OP_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
            OP_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned gid(input int unsigned k);
        if (k < g_id.size()) return g_id[k];
        return 99;
    endfunction

    // Drive one operation, wait for its grant, then record the expected response
    task automatic issue(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] er, input logic ez,
                         output int unsigned waited);
        bit   acc = 0;
        exp_t e;
        waited = 0;
        e.res  = er;
        e.z    = ez;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        while (!acc && waited < 60) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) acc = 1;
            else waited++;
        end
        if (acc) begin
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout_req%0d: got no ready, expected ready within 60 cycles", id);
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    // Monitor: log grants, pop and compare each consumed response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req0_ready && req1_ready) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dual_ready: got both readies 1, expected at most one");
                end
                if (req0_valid && req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
                if (req1_valid && req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
                if (rsp0_valid && rsp0_ready) begin
                    if (q0.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp0_unexpected: got result %h, expected no response", rsp0_result);
                    end else begin
                        e = q0.pop_front();
                        chk("rsp0_result", rsp0_result, e.res);
                        chk("rsp0_zero", 32'(rsp0_zero), 32'(e.z));
                    end
                end
                if (rsp1_valid && rsp1_ready) begin
                    if (q1.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp1_unexpected: got result %h, expected no response", rsp1_result);
                    end else begin
                        e = q1.pop_front();
                        chk("rsp1_result", rsp1_result, e.res);
                        chk("rsp1_zero", 32'(rsp1_zero), 32'(e.z));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
        chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
        chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
        chk({tag, "_rsp0_zero"}, 32'(rsp0_zero), 32'd0);
        chk({tag, "_rsp1_zero"}, 32'(rsp1_zero), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned w, w0, w1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single SUB: grant in the first cycle, response one cycle after acceptance
        issue(0, 32'd5, 32'd3, OP_SUB, 32'd2, 1'b0, w);
        chk("t1_accept_wait", w, 32'd0);
        chk("t1_rsp0_valid_exec", 32'(rsp0_valid), 32'd0);
        chk("t1_busy_exec", 32'(busy), 32'd1);
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_op", 32'(alu_op), 32'(OP_SUB));
        @(posedge clk);
        #1;
        chk("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("t1_rsp0_result", rsp0_result, 32'd2);
        chk("t1_rsp0_zero", 32'(rsp0_zero), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_rsp0_drained", 32'(rsp0_valid), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Both requesters streaming; req0 was granted last, so req1 wins the first tie
        g_id.delete();
        g_cyc.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, w0);
            end
            begin
                for (int i = 0; i < 4; i++) issue(1, 32'd7, 32'd7, OP_XOR, 32'd0, 1'b1, w1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t2_grant_count", g_id.size(), 32'd8);
        for (int unsigned k = 0; k < 8; k++) begin
            chk("t2_grant_order", gid(k), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        if (g_cyc.size() == 8) begin
            chk("t2_grant_span_cycles", g_cyc[7] - g_cyc[0], 32'd7);
        end

        // Held rsp1 blocks only req1; releasing it grants req1 in the same cycle
        rsp1_ready = 1'b0;
        issue(1, 32'd10, 32'd20, OP_ADD, 32'd30, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_rsp1_held", 32'(rsp1_valid), 32'd1);
        g_id.delete();
        g_cyc.delete();
        fork
            issue(1, 32'd3, 32'd3, OP_SUB, 32'd0, 1'b1, w1);
        join_none
        issue(0, 32'hFFFF0000, 32'h12345678, OP_AND, 32'h12340000, 1'b0, w0);
        issue(0, 32'h000000F0, 32'h0000000F, OP_OR, 32'h000000FF, 1'b0, w0);
        issue(0, 32'h00000001, 32'd31, OP_SLL, 32'h80000000, 1'b0, w0);
        chk("t3_req1_blocked", 32'(req1_ready), 32'd0);
        chk("t3_rsp1_still_held", rsp1_result, 32'd30);
        chk("t3_req0_grants", g_id.size(), 32'd3);
        chk("t3_no_req1_grant", gid(0) + gid(1) + gid(2), 32'd0);
        rsp1_ready = 1'b1;
        #1;
        chk("t3_req1_ready_on_release", 32'(req1_ready), 32'd1);
        wait fork;
        repeat (3) @(posedge clk);
        #1;

        // Unlisted opcode and the shift/compare corner cases
        issue(0, 32'h00001234, 32'h00005678, 4'hF, 32'd0, 1'b1, w);
        issue(1, 32'h80000000, 32'd4, OP_SRA, 32'hF8000000, 1'b0, w);
        issue(1, 32'h80000000, 32'd4, OP_SRL, 32'h08000000, 1'b0, w);
        issue(1, 32'd1, 32'hFFFFFFFF, OP_SLTU, 32'd1, 1'b0, w);
        issue(0, 32'd1, 32'hFFFFFFFF, OP_SLT, 32'd0, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_q0_empty", q0.size(), 32'd0);
        chk("t5_q1_empty", q1.size(), 32'd0);

        // Asynchronous reset during EXEC with a buffered rsp0
        rsp0_ready = 1'b0;
        issue(0, 32'd1, 32'd2, OP_ADD, 32'd3, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_rsp0_pending", 32'(rsp0_valid), 32'd1);
        issue(1, 32'd5, 32'd5, OP_ADD, 32'd10, 1'b0, w);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        q0.delete();
        q1.delete();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t6_no_rsp0", 32'(rsp0_valid), 32'd0);
            chk("t6_no_rsp1", 32'(rsp1_valid), 32'd0);
        end
        g_id.delete();
        g_cyc.delete();
        fork
            issue(0, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1, w0);
            issue(1, 32'd4, 32'd5, OP_OR, 32'd5, 1'b0, w1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t6_first_tie_req0", gid(0), 32'd0);
        chk("t6_second_grant_req1", gid(1), 32'd1);
        chk("end_q0_empty", q0.size(), 32'd0);
        chk("end_q1_empty", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
